// File: rtl/rv32_m_arbiter_pkg.sv
// Shared types and constants for the round-robin front end of the shared M unit.
package rv32_m_arbiter_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rv32_m_rr_pick.sv
// Combinational round-robin picker: the request at ptr has highest priority,
// then ascending indices with wrap-around.
module rv32_m_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic               valid,
  output logic [PTR_W-1:0]   winner
);

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  // Scan from the farthest offset down so the closest request to ptr wins last.
  always_comb begin
    valid  = |req;
    winner = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[wrap_add(ptr, i)]) winner = wrap_add(ptr, i);
    end
  end

endmodule

// File: rtl/rv32_m_arbiter.sv
// Round-robin arbiter sharing one multiply/divide unit between NUM_REQ requesters.
module rv32_m_arbiter
  import rv32_m_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_REQ-1:0]      i_req_en,
  input  logic [NUM_REQ*XLEN-1:0] i_req_rs1,
  input  logic [NUM_REQ*XLEN-1:0] i_req_rs2,
  input  logic [NUM_REQ*3-1:0]    i_req_f3,
  output logic [XLEN-1:0]         o_req_res,
  output logic [NUM_REQ-1:0]      o_req_ack,
  output logic                    o_busy,
  output logic                    o_m_en,
  output logic [XLEN-1:0]         o_m_rs1,
  output logic [XLEN-1:0]         o_m_rs2,
  output logic [2:0]              o_m_f3,
  input  logic [XLEN-1:0]         i_m_res,
  input  logic                    i_m_ack
);

  arb_state_t       state;
  arb_state_t       next_state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant;
  logic             pick_valid;
  logic [PTR_W-1:0] pick_idx;

  rv32_m_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req    (i_req_en),
    .ptr    (rr_ptr),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:  if (pick_valid) next_state = ST_ISSUE;
      ST_ISSUE: next_state = ST_WAIT;
      ST_WAIT:  if (i_m_ack) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy    = (state != ST_IDLE);
    o_m_en    = (state == ST_ISSUE);
    o_req_ack = '0;
    if (state == ST_DONE) o_req_ack[grant] = 1'b1;
  end

  // Operands are captured only in IDLE, so requesters may change them once granted.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rr_ptr    <= '0;
      grant     <= '0;
      o_m_rs1   <= '0;
      o_m_rs2   <= '0;
      o_m_f3    <= '0;
      o_req_res <= '0;
    end else begin
      if (state == ST_IDLE && pick_valid) begin
        grant   <= pick_idx;
        o_m_rs1 <= i_req_rs1[int'(pick_idx)*XLEN +: XLEN];
        o_m_rs2 <= i_req_rs2[int'(pick_idx)*XLEN +: XLEN];
        o_m_f3  <= i_req_f3[int'(pick_idx)*3 +: 3];
      end
      if (state == ST_WAIT && i_m_ack) o_req_res <= i_m_res;
      if (state == ST_DONE) begin
        if (grant == PTR_W'(NUM_REQ - 1)) rr_ptr <= '0;
        else                              rr_ptr <= grant + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rv32_m_arbiter.sv
// Directed bench for rv32_m_arbiter with a behavioural M unit of programmable latency.
module tb_rv32_m_arbiter;

  logic        i_clk;
  logic        i_rst;
  logic [1:0]  i_req_en;
  logic [63:0] i_req_rs1;
  logic [63:0] i_req_rs2;
  logic [5:0]  i_req_f3;
  logic [31:0] o_req_res;
  logic [1:0]  o_req_ack;
  logic        o_busy;
  logic        o_m_en;
  logic [31:0] o_m_rs1;
  logic [31:0] o_m_rs2;
  logic [2:0]  o_m_f3;
  logic [31:0] i_m_res;
  logic        i_m_ack;

  int pass_cnt  = 0;
  int total_cnt = 0;

  rv32_m_arbiter #(.NUM_REQ(2), .PTR_W(1)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_req_en  (i_req_en),
    .i_req_rs1 (i_req_rs1),
    .i_req_rs2 (i_req_rs2),
    .i_req_f3  (i_req_f3),
    .o_req_res (o_req_res),
    .o_req_ack (o_req_ack),
    .o_busy    (o_busy),
    .o_m_en    (o_m_en),
    .o_m_rs1   (o_m_rs1),
    .o_m_rs2   (o_m_rs2),
    .o_m_f3    (o_m_f3),
    .i_m_res   (i_m_res),
    .i_m_ack   (i_m_ack)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] mcalc(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'b000:  mcalc = a * b;
      3'b100:  mcalc = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'b101:  mcalc = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110:  mcalc = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      3'b111:  mcalc = (b == 0) ? a : a % b;
      default: mcalc = 32'd0;
    endcase
  endfunction

  // Behavioural M unit: acks m_lat cycles after the enable; spur injects stray acks.
  logic        m_ack_q;
  logic        m_busy;
  logic [31:0] m_res_q;
  int          m_cnt;
  int          m_lat;
  logic        spur;

  always @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      m_ack_q <= 1'b0;
      m_busy  <= 1'b0;
      m_cnt   <= 0;
      m_res_q <= '0;
    end else begin
      m_ack_q <= 1'b0;
      if (o_m_en) begin
        m_busy  <= 1'b1;
        m_cnt   <= m_lat;
        m_res_q <= mcalc(o_m_rs1, o_m_rs2, o_m_f3);
      end else if (m_busy) begin
        if (m_cnt <= 1) begin
          m_ack_q <= 1'b1;
          m_busy  <= 1'b0;
        end
        m_cnt <= m_cnt - 1;
      end
    end
  end

  assign i_m_ack = m_ack_q | spur;
  assign i_m_res = m_res_q;

  typedef struct {
    string       name;
    int          req;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  f3;
    int          lat;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[4];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_cnt++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    else
      pass_cnt++;
  endtask

  task automatic setOperands(input int k, input logic [31:0] rs1, input logic [31:0] rs2, input logic [2:0] f3);
    i_req_rs1[k*32 +: 32] = rs1;
    i_req_rs2[k*32 +: 32] = rs2;
    i_req_f3[k*3 +: 3]    = f3;
  endtask

  task automatic waitAck(input bit scramble, output logic [1:0] ack, output int cyc, output int en_cnt);
    ack    = '0;
    cyc    = 0;
    en_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      cyc++;
      if (o_m_en) begin
        en_cnt++;
        if (scramble) begin
          i_req_rs1 = ~i_req_rs1;
          i_req_rs2 = ~i_req_rs2;
          i_req_f3  = ~i_req_f3;
        end
      end
      if (o_req_ack != 2'b00) begin
        ack = o_req_ack;
        break;
      end
    end
    if (ack == 2'b00) checkOutput("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [1:0] ack;
    int         cyc;
    int         en_cnt;
    m_lat = v.lat;
    setOperands(v.req, v.rs1, v.rs2, v.f3);
    i_req_en = 2'b00;
    i_req_en[v.req] = 1'b1;
    waitAck(1'b1, ack, cyc, en_cnt);
    checkOutput({v.name, "_ack"}, 32'(ack), 32'(2'b01 << v.req));
    checkOutput({v.name, "_res"}, o_req_res, v.exp_res);
    checkOutput({v.name, "_rs2_held"}, o_m_rs2, v.rs2);
    checkOutput({v.name, "_en_pulses"}, 32'(en_cnt), 32'd1);
    checkOutput({v.name, "_latency"}, 32'(cyc), 32'(3 + v.lat));
    i_req_en = 2'b00;
    @(negedge i_clk);
    checkOutput({v.name, "_busy_after"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    logic [1:0] ack;
    int         cyc;
    int         en_cnt;
    int         ack_seen;
    vec_t       ovf_vec;

    vecs[0] = '{"mul_7x6",   0, 32'd7,   32'd6, 3'b000, 1, 32'd42};
    vecs[1] = '{"divu_100_7", 1, 32'd100, 32'd7, 3'b101, 3, 32'd14};
    vecs[2] = '{"remu_100_7", 1, 32'd100, 32'd7, 3'b111, 2, 32'd2};
    vecs[3] = '{"div_by_0",  0, 32'd55,  32'd0, 3'b100, 1, 32'hFFFF_FFFF};
    ovf_vec = '{"div_ovf", 1, 32'h8000_0000, 32'hFFFF_FFFF, 3'b100, 2, 32'h8000_0000};

    i_rst     = 1'b0;
    i_req_en  = 2'b00;
    i_req_rs1 = '0;
    i_req_rs2 = '0;
    i_req_f3  = '0;
    spur      = 1'b0;
    m_lat     = 1;

    repeat (3) @(negedge i_clk);
    checkOutput("rst_res",  o_req_res, 32'd0);
    checkOutput("rst_ack",  32'(o_req_ack), 32'd0);
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_m_en", 32'(o_m_en), 32'd0);
    checkOutput("rst_m_rs1", o_m_rs1, 32'd0);
    i_rst = 1'b1;
    @(negedge i_clk);

    $display("[TB] simultaneous requests");
    setOperands(0, 32'd3, 32'd5, 3'b000);
    setOperands(1, 32'd4, 32'd4, 3'b000);
    i_req_en = 2'b11;
    waitAck(1'b0, ack, cyc, en_cnt);
    checkOutput("simul_first_ack", 32'(ack), 32'd1);
    checkOutput("simul_first_res", o_req_res, 32'd15);
    i_req_en = 2'b10;
    waitAck(1'b0, ack, cyc, en_cnt);
    checkOutput("simul_second_ack", 32'(ack), 32'd2);
    checkOutput("simul_second_res", o_req_res, 32'd16);
    i_req_en = 2'b00;
    @(negedge i_clk);

    $display("[TB] fairness");
    setOperands(0, 32'd2, 32'd3, 3'b000);
    setOperands(1, 32'd5, 32'd3, 3'b000);
    i_req_en = 2'b11;
    for (int j = 0; j < 6; j++) begin
      waitAck(1'b0, ack, cyc, en_cnt);
      checkOutput($sformatf("fair_order_%0d", j), 32'(ack), (j % 2 == 0) ? 32'd1 : 32'd2);
      checkOutput($sformatf("fair_res_%0d", j), o_req_res, (j % 2 == 0) ? 32'd6 : 32'd15);
    end
    i_req_en = 2'b00;
    @(negedge i_clk);

    $display("[TB] table vectors");
    for (int n = 0; n < 4; n++) applyStimulus(vecs[n]);

    $display("[TB] spurious ack in idle");
    spur = 1'b1;
    @(negedge i_clk);
    spur = 1'b0;
    ack_seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      if (o_req_ack != 2'b00 || o_busy) ack_seen++;
    end
    checkOutput("spur_no_activity", 32'(ack_seen), 32'd0);
    checkOutput("spur_res_held", o_req_res, 32'hFFFF_FFFF);

    $display("[TB] reset mid-operation");
    m_lat = 6;
    setOperands(0, 32'd9, 32'd9, 3'b000);
    i_req_en = 2'b01;
    repeat (3) @(negedge i_clk);
    checkOutput("pre_rst_busy", 32'(o_busy), 32'd1);
    #2 i_rst = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 32'(o_busy), 32'd0);
    checkOutput("mid_rst_res",  o_req_res, 32'd0);
    checkOutput("mid_rst_m_rs1", o_m_rs1, 32'd0);
    i_req_en = 2'b00;
    @(negedge i_clk);
    i_rst = 1'b1;
    ack_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      if (o_req_ack != 2'b00) ack_seen++;
    end
    checkOutput("mid_rst_no_ack", 32'(ack_seen), 32'd0);

    applyStimulus(ovf_vec);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rv32_m_arbiter.md
Name: rv32_m_arbiter

Overview:
- Round-robin arbiter that shares one rv32_m_external multiply/divide unit between NUM_REQ requesters, such as multiple harts or a core plus an accelerator.
- Latches the winning requester's operands, drives the unit's enable for one cycle, waits for its ack, then returns the result and a one-cycle ack to the granted requester.
- Sits between the requesters and the shared M unit.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- PTR_W, 1, width of the grant/round-robin pointer; must equal clog2(NUM_REQ).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-low reset.
- i_req_en  in  NUM_REQ  per-requester operation request, level-sensitive.
- i_req_rs1  in  NUM_REQ*XLEN  flattened operand 1; requester k occupies bits [k*XLEN +: XLEN].
- i_req_rs2  in  NUM_REQ*XLEN  flattened operand 2, same packing as i_req_rs1.
- i_req_f3  in  NUM_REQ*3  flattened funct3; requester k occupies bits [k*3 +: 3].
- o_req_res  out  XLEN  result of the last completed operation, broadcast to all requesters.
- o_req_ack  out  NUM_REQ  one-hot, one-cycle completion pulse.
- o_busy  out  1  high while an operation is in flight (any state except IDLE).
- o_m_en  out  1  enable pulse to the M unit.
- o_m_rs1  out  XLEN  latched operand 1 to the M unit.
- o_m_rs2  out  XLEN  latched operand 2 to the M unit.
- o_m_f3  out  3  latched funct3 to the M unit.
- i_m_res  in  XLEN  M unit result.
- i_m_ack  in  1  M unit completion pulse.

Behaviour:
- Reset (asynchronous assert, synchronous deassert by the driving logic):
  - state=IDLE, rr_ptr=0, grant=0.
  - All outputs 0, including o_req_res.
- Reset mid-operation: the operation is abandoned and no ack is issued. The M unit shares i_rst and is reset with the arbiter.
- States:
  - IDLE: if any bit of i_req_en is set, pick the winner by round-robin starting at rr_ptr (rr_ptr has highest priority, then ascending with wrap-around). Latch that requester's rs1/rs2/f3 into o_m_*, store grant, go to ISSUE. With no request, stay in IDLE.
  - ISSUE: o_m_en=1 for exactly this cycle. Go to WAIT.
  - WAIT: o_m_en=0. On i_m_ack=1, register i_m_res into o_req_res and go to DONE. Otherwise stay.
  - DONE: o_req_ack[grant]=1 for this cycle only. rr_ptr <= (grant+1) mod NUM_REQ. Go to IDLE. i_req_en is not sampled in DONE.
- Requester contract:
  - Hold i_req_en high until the o_req_ack cycle.
  - i_req_en must be low in the cycle after the ack unless the requester is issuing a new operation.
  - Operands may change once the arbiter leaves IDLE; they are already latched.
- Request withdrawn after grant: the operation still completes and the ack is still pulsed.
- Spurious i_m_ack in IDLE, ISSUE or DONE: ignored.
- o_m_rs1, o_m_rs2 and o_m_f3 are stable from ISSUE through DONE.
- o_req_res holds its value until the next completion. It is valid in the ack cycle and afterwards.
- Latency: requester sampled at edge E in IDLE; o_m_en high in cycle E+1; i_m_ack arrives L cycles after the enable; o_req_ack follows one cycle after i_m_ack. Arbiter overhead is 3 cycles beyond the M unit latency.
- Back-to-back operation: a new grant is possible in the IDLE cycle immediately after DONE.
- Fairness: with all requesters continuously requesting, grants cycle 0,1,…,NUM_REQ-1,0,…
- Width rules: all data is XLEN bits and passes through unmodified. The arbiter performs no arithmetic; divide-by-zero and overflow results come from the M unit.

Decomposition:
- XLEN comes from arvi_defines.vh.
- The state encoding (IDLE=0, ISSUE=1, WAIT=2, DONE=3) goes in a shared include, rv32_m_arbiter_defines.vh, for bench visibility.
- One combinational sub-module: rv32_m_rr_pick.
  - Inputs: request vector, rr_ptr.
  - Outputs: valid and winner index.

Test Plan:
- Single MUL: req0, rs1=7, rs2=6, f3=000 → o_m_en pulses once; o_req_res=42 with o_req_ack=01 one cycle after i_m_ack; o_busy falls the next cycle.
- DIVU on requester 1: rs1=100, rs2=7, f3=101 → o_req_res=14, o_req_ack=10. Then REMU with the same operands (f3=111) → o_req_res=2.
- Simultaneous requests with rr_ptr=0: req0 MUL 3*5 and req1 MUL 4*4 raised together → req0 acked first with 15, then req1 acked with 16. rr_ptr ends at 0.
- Fairness: both requesters held high for 6 operations → ack order 0,1,0,1,0,1 with no starvation.
- Reset mid-operation: assert i_rst low during WAIT → all outputs 0 asynchronously and no ack. After release, a fresh req1 DIV with rs1=0x80000000, rs2=0xFFFFFFFF (f3=100) → o_req_res=0x80000000.
- Robustness: spurious i_m_ack injected in IDLE → no ack, state stays IDLE. Divide by zero, DIV f3=100 with rs2=0 → o_req_res=0xFFFFFFFF passed through unmodified.
